// File: rtl/cyl_convert_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// cyl_pkg
// Shared constants and the result record type for the cylindrical converter
// arbiter. The result record is sized for the largest supported requester
// count (8), so the arbiter top can be built for 2..8 requesters without
// touching the package. Theta width follows the default rotational
// resolution of the converter.
// ---------------------------------------------------------------------------
package cyl_pkg;

    // Default configuration of the shared converter
    localparam int NUM_REQ_DEF               = 3;
    localparam int NUM_REQ_MAX               = 8;
    localparam int CONV_LATENCY_DEF          = 2;
    localparam int ROTATIONAL_RESOLUTION_DEF = 64;

    // Field widths
    localparam int TW       = $clog2(ROTATIONAL_RESOLUTION_DEF);
    localparam int ID_W     = $clog2(NUM_REQ_MAX);
    localparam int RADIUS_W = 6;
    localparam int ZOUT_W   = 6;
    localparam int COORD_W  = 8;

    // One converted point, tagged with the requester that issued it
    typedef struct packed {
        logic [ID_W-1:0]     id;
        logic [TW-1:0]       theta;
        logic [RADIUS_W-1:0] radius;
        logic [ZOUT_W-1:0]   z;
    } cyl_result_t;

endpackage

// File: rtl/cyl_convert_arbiter_result_fifo.sv
// ---------------------------------------------------------------------------
// cyl_result_fifo
// Synchronous first-word-fall-through FIFO holding converter results.
// The head entry is visible on head_o whenever empty_o is low; pop_i
// consumes it. Push and pop in the same cycle are accepted at any
// occupancy, including full (the pop makes room for the push). A push
// into a full FIFO without a pop is ignored; the owner is expected to
// flag that condition.
//
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset (empties the FIFO)
//   push_i       write push_data_i at the tail
//   push_data_i  result record to write
//   pop_i        consume the head entry (ignored when empty)
//   head_o       head entry (only meaningful when empty_o is low)
//   empty_o      FIFO holds no entries
//   full_o       FIFO holds DEPTH entries
//   count_o      current occupancy 0..DEPTH
// ---------------------------------------------------------------------------
module cyl_result_fifo
    import cyl_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  cyl_result_t   push_data_i,
    input  logic          pop_i,
    output cyl_result_t   head_o,
    output logic          empty_o,
    output logic          full_o,
    output logic [CW-1:0] count_o
);

    cyl_result_t   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A pop frees the slot in the same edge, so push-while-full is fine
    // as long as the head leaves at the same time.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Pointer and occupancy next-state; DEPTH is a power of two so the
    // pointers simply wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing is visible until count_q says so.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/cyl_convert_arbiter.sv
// ---------------------------------------------------------------------------
// cyl_convert_arbiter
// Shares one fixed-latency cartesian-to-cylindrical converter among
// NUM_REQ point sources. A round-robin arbiter grants at most one point
// per cycle, the point is registered onto the converter inputs, and the
// requester ID travels alongside it in a tag shift register. When the
// converter result appears, it is written with its ID into a result FIFO.
// The converter cannot be stalled, so issue is limited by credits: a point
// is only granted when the FIFO is guaranteed to have room for it.
//
// Ports:
//   clk_in, rst_in        clock, synchronous active-high reset
//   enable_in             allow new grants (in-flight points always drain)
//   req_valid/req_ready   per-requester handshake, req_ready is one-hot
//   req_x/req_y/req_z     per-requester cartesian coordinates
//   cv_x/cv_y/cv_z        registered coordinates to the converter
//   cv_new_data           registered strobe to the converter
//   cv_theta/cv_radius    converter results
//   cv_zout               converter z output (z_out)
//   cv_data_ready         converter result strobe
//   rsp_valid/rsp_ready   result handshake at the FIFO head
//   rsp_id                requester that issued the head result
//   rsp_theta/radius/z    head result (zero while rsp_valid is low)
//   sync_err              sticky: converter strobe and tag pipe disagreed,
//                         or a result arrived with the FIFO full
// ---------------------------------------------------------------------------
module cyl_convert_arbiter
    import cyl_pkg::*;
#(
    parameter  int NUM_REQ               = NUM_REQ_DEF,
    parameter  int CONV_LATENCY          = CONV_LATENCY_DEF,
    parameter  int FIFO_DEPTH            = 8,
    parameter  int ROTATIONAL_RESOLUTION = ROTATIONAL_RESOLUTION_DEF,
    localparam int THETA_W               = $clog2(ROTATIONAL_RESOLUTION),
    localparam int ID_BITS               = $clog2(NUM_REQ),
    localparam int CW                    = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              enable_in,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ-1:0][COORD_W-1:0]   req_x,
    input  logic [NUM_REQ-1:0][COORD_W-1:0]   req_y,
    input  logic [NUM_REQ-1:0][COORD_W-1:0]   req_z,
    output logic [COORD_W-1:0]                cv_x,
    output logic [COORD_W-1:0]                cv_y,
    output logic [COORD_W-1:0]                cv_z,
    output logic                              cv_new_data,
    input  logic [THETA_W-1:0]                cv_theta,
    input  logic [RADIUS_W-1:0]               cv_radius,
    input  logic [ZOUT_W-1:0]                 cv_zout,
    input  logic                              cv_data_ready,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [ID_BITS-1:0]                rsp_id,
    output logic [THETA_W-1:0]                rsp_theta,
    output logic [RADIUS_W-1:0]               rsp_radius,
    output logic [ZOUT_W-1:0]                 rsp_z,
    output logic                              sync_err
);

    localparam int RRW = ID_BITS + 1;

    // Round-robin state and grant
    logic [ID_BITS-1:0] rr_last_q, rr_last_d;
    logic [ID_BITS-1:0] grant_idx;
    logic               grant_found;
    logic [NUM_REQ-1:0] grant_oh;
    logic               can_issue;
    logic               transfer;

    // Issue register feeding the converter
    logic [COORD_W-1:0] cv_x_q, cv_x_d;
    logic [COORD_W-1:0] cv_y_q, cv_y_d;
    logic [COORD_W-1:0] cv_z_q, cv_z_d;
    logic               cv_new_data_q, cv_new_data_d;
    logic [ID_BITS-1:0] issue_id_q, issue_id_d;

    // Tag pipe: mirrors the converter latency behind the issue register
    logic [CONV_LATENCY-1:0]              tag_valid_q, tag_valid_d;
    logic [CONV_LATENCY-1:0][ID_BITS-1:0] tag_id_q, tag_id_d;
    logic                                 tag_head_valid;
    logic [ID_BITS-1:0]                   tag_head_id;

    // Credits and result path
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   credit_sum;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push_req;
    logic          pop;
    logic          overflow;
    logic          mismatch;
    logic          sync_err_q, sync_err_d;
    cyl_result_t   push_data;
    cyl_result_t   fifo_head;

    // Credit check uses only registered counts, so a pop this cycle does
    // not open a slot until the next cycle. Every point that may still
    // produce a result is counted, which keeps the FIFO from overflowing
    // even though the converter never waits.
    assign credit_sum = {1'b0, fifo_count} + {1'b0, inflight_q};
    assign can_issue  = enable_in && (credit_sum < RRW'(0) + (CW+1)'(FIFO_DEPTH));

    // Search the requesters starting just after the last granted one and
    // wrapping; the first valid one wins. The candidate index is kept one
    // bit wider so the wrap subtraction cannot overflow.
    always_comb begin
        logic [RRW-1:0] cand_w;
        grant_idx   = rr_last_q;
        grant_found = 1'b0;
        grant_oh    = '0;
        cand_w      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand_w = {1'b0, rr_last_q} + RRW'(i);
            if (cand_w >= RRW'(NUM_REQ)) begin
                cand_w = cand_w - RRW'(NUM_REQ);
            end
            if (!grant_found && req_valid[cand_w[ID_BITS-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand_w[ID_BITS-1:0];
            end
        end
        if (can_issue && grant_found) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

    assign req_ready = grant_oh;
    assign transfer  = can_issue && grant_found;

    // Issue register and round-robin pointer. Coordinates hold their last
    // value between points so the converter inputs stay quiet.
    always_comb begin
        rr_last_d     = rr_last_q;
        cv_x_d        = cv_x_q;
        cv_y_d        = cv_y_q;
        cv_z_d        = cv_z_q;
        issue_id_d    = issue_id_q;
        cv_new_data_d = transfer;
        if (transfer) begin
            rr_last_d  = grant_idx;
            cv_x_d     = req_x[grant_idx];
            cv_y_d     = req_y[grant_idx];
            cv_z_d     = req_z[grant_idx];
            issue_id_d = grant_idx;
        end
    end

    // The tag pipe starts from the issue register, so its head lines up
    // with cv_data_ready CONV_LATENCY cycles after cv_new_data.
    always_comb begin
        tag_valid_d    = tag_valid_q;
        tag_id_d       = tag_id_q;
        tag_valid_d[0] = cv_new_data_q;
        tag_id_d[0]    = issue_id_q;
        for (int i = 1; i < CONV_LATENCY; i++) begin
            tag_valid_d[i] = tag_valid_q[i-1];
            tag_id_d[i]    = tag_id_q[i-1];
        end
    end

    assign tag_head_valid = tag_valid_q[CONV_LATENCY-1];
    assign tag_head_id    = tag_id_q[CONV_LATENCY-1];

    // A result is only written when the converter and the tag pipe agree.
    // Any disagreement, or a result arriving with no room, is latched in
    // sync_err and the result is discarded.
    assign push_req = tag_head_valid && cv_data_ready;
    assign mismatch = tag_head_valid != cv_data_ready;
    assign pop      = rsp_valid && rsp_ready;
    assign overflow = push_req && fifo_full && !pop;
    assign sync_err_d = sync_err_q || mismatch || overflow;

    assign push_data = '{
        id:     ID_W'(tag_head_id),
        theta:  TW'(cv_theta),
        radius: cv_radius,
        z:      cv_zout
    };

    // A point stops consuming a credit once its tag leaves the pipe,
    // whether its result was written or dropped.
    always_comb begin
        inflight_d = inflight_q;
        case ({transfer, tag_head_valid})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rr_last_q     <= ID_BITS'(NUM_REQ - 1);
            cv_x_q        <= '0;
            cv_y_q        <= '0;
            cv_z_q        <= '0;
            cv_new_data_q <= 1'b0;
            issue_id_q    <= '0;
            tag_valid_q   <= '0;
            tag_id_q      <= '0;
            inflight_q    <= '0;
            sync_err_q    <= 1'b0;
        end else begin
            rr_last_q     <= rr_last_d;
            cv_x_q        <= cv_x_d;
            cv_y_q        <= cv_y_d;
            cv_z_q        <= cv_z_d;
            cv_new_data_q <= cv_new_data_d;
            issue_id_q    <= issue_id_d;
            tag_valid_q   <= tag_valid_d;
            tag_id_q      <= tag_id_d;
            inflight_q    <= inflight_d;
            sync_err_q    <= sync_err_d;
        end
    end

    cyl_result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_result_fifo (
        .clk_i       (clk_in),
        .rst_i       (rst_in),
        .push_i      (push_req),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full),
        .count_o     (fifo_count)
    );

    assign cv_x        = cv_x_q;
    assign cv_y        = cv_y_q;
    assign cv_z        = cv_z_q;
    assign cv_new_data = cv_new_data_q;
    assign sync_err    = sync_err_q;

    // Result fields read as zero whenever nothing is at the head
    assign rsp_valid  = !fifo_empty;
    assign rsp_id     = rsp_valid ? ID_BITS'(fifo_head.id) : '0;
    assign rsp_theta  = rsp_valid ? THETA_W'(fifo_head.theta) : '0;
    assign rsp_radius = rsp_valid ? fifo_head.radius : '0;
    assign rsp_z      = rsp_valid ? fifo_head.z : '0;

endmodule

// File: tb/tb_cyl_convert_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cyl_convert_arbiter
// Directed testbench for cyl_convert_arbiter with a small converter model
// (two-stage pipeline, theta = x + 2y, radius = x ^ y, z_out = z[5:0]).
// Inputs change on the falling edge and outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_cyl_convert_arbiter;

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic             enable_in;
    logic [2:0]       req_valid;
    logic [2:0]       req_ready;
    logic [2:0][7:0]  req_x;
    logic [2:0][7:0]  req_y;
    logic [2:0][7:0]  req_z;
    logic [7:0]       cv_x;
    logic [7:0]       cv_y;
    logic [7:0]       cv_z;
    logic             cv_new_data;
    logic [5:0]       cv_theta;
    logic [5:0]       cv_radius;
    logic [5:0]       cv_zout;
    logic             cv_data_ready;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [1:0]       rsp_id;
    logic [5:0]       rsp_theta;
    logic [5:0]       rsp_radius;
    logic [5:0]       rsp_z;
    logic             sync_err;

    int nChecks = 0;
    int nErrors = 0;

    // Converter model state
    logic [1:0]        mValid;
    logic [1:0][17:0]  mData;
    logic              inject;

    always #5 clk_in = ~clk_in;

    cyl_convert_arbiter dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .enable_in     (enable_in),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_x         (req_x),
        .req_y         (req_y),
        .req_z         (req_z),
        .cv_x          (cv_x),
        .cv_y          (cv_y),
        .cv_z          (cv_z),
        .cv_new_data   (cv_new_data),
        .cv_theta      (cv_theta),
        .cv_radius     (cv_radius),
        .cv_zout       (cv_zout),
        .cv_data_ready (cv_data_ready),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_theta     (rsp_theta),
        .rsp_radius    (rsp_radius),
        .rsp_z         (rsp_z),
        .sync_err      (sync_err)
    );

    // Converter model: result appears two cycles after new_data
    always @(posedge clk_in) begin
        if (rst_in) begin
            mValid <= '0;
            mData  <= '0;
        end else begin
            mValid   <= {mValid[0], cv_new_data};
            mData[0] <= {6'(cv_x + (cv_y << 1)), 6'(cv_x ^ cv_y), cv_z[5:0]};
            mData[1] <= mData[0];
        end
    end

    assign cv_data_ready = mValid[1] | inject;
    assign {cv_theta, cv_radius, cv_zout} = mData[1];

    // Reset values of every output
    task automatic test_reset();
        rst_in    = 1'b1;
        enable_in = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        inject    = 1'b0;
        req_x     = '0;
        req_y     = '0;
        req_z     = '0;
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        #1;
        nChecks++;
        if (req_ready !== 3'b000) begin nErrors++; $display("[TB] FAIL reset_req_ready got=%b exp=000", req_ready); end
        nChecks++;
        if (cv_new_data !== 1'b0) begin nErrors++; $display("[TB] FAIL reset_cv_new_data got=%b exp=0", cv_new_data); end
        nChecks++;
        if ({cv_x, cv_y, cv_z} !== 24'h0) begin nErrors++; $display("[TB] FAIL reset_cv_xyz got=%h exp=0", {cv_x, cv_y, cv_z}); end
        nChecks++;
        if (rsp_valid !== 1'b0) begin nErrors++; $display("[TB] FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        nChecks++;
        if ({rsp_id, rsp_theta, rsp_radius, rsp_z} !== 20'h0) begin nErrors++; $display("[TB] FAIL reset_rsp_fields got=%h exp=0", {rsp_id, rsp_theta, rsp_radius, rsp_z}); end
        nChecks++;
        if (sync_err !== 1'b0) begin nErrors++; $display("[TB] FAIL reset_sync_err got=%b exp=0", sync_err); end
    endtask

    // All three valid for 9 cycles with the consumer always ready
    task automatic test_round_robin();
        logic [2:0] expReady;
        for (int i = 0; i < 3; i++) begin
            req_x[i] = 8'(10 + i);
            req_y[i] = 8'(20 + i);
            req_z[i] = 8'(30 + i);
        end
        enable_in = 1'b1;
        rsp_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            req_valid = (c < 9) ? 3'b111 : 3'b000;
            #1;
            expReady = (c < 9) ? 3'(1 << (c % 3)) : 3'b000;
            nChecks++;
            if (req_ready !== expReady) begin nErrors++; $display("[TB] FAIL rr_req_ready c=%0d got=%b exp=%b", c, req_ready, expReady); end
            nChecks++;
            if (cv_new_data !== 1'(c >= 1 && c <= 9)) begin nErrors++; $display("[TB] FAIL rr_cv_new_data c=%0d got=%b", c, cv_new_data); end
            if (c >= 1 && c <= 9) begin
                nChecks++;
                if (cv_x !== 8'(10 + (c - 1) % 3)) begin nErrors++; $display("[TB] FAIL rr_cv_x c=%0d got=%0d exp=%0d", c, cv_x, 10 + (c - 1) % 3); end
            end
            nChecks++;
            if (rsp_valid !== 1'(c >= 4 && c <= 12)) begin nErrors++; $display("[TB] FAIL rr_rsp_valid c=%0d got=%b", c, rsp_valid); end
            if (c >= 4 && c <= 12) begin
                nChecks++;
                if (rsp_id !== 2'((c - 4) % 3)) begin nErrors++; $display("[TB] FAIL rr_rsp_id c=%0d got=%0d exp=%0d", c, rsp_id, (c - 4) % 3); end
            end
            @(negedge clk_in);
        end
    endtask

    // One point from requester 1 followed through the converter
    task automatic test_single_point();
        req_x[1]  = 8'd5;
        req_y[1]  = 8'd7;
        req_z[1]  = 8'd40;
        rsp_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            req_valid = (c == 0) ? 3'b010 : 3'b000;
            #1;
            if (c == 0) begin
                nChecks++;
                if (req_ready !== 3'b010) begin nErrors++; $display("[TB] FAIL single_req_ready got=%b exp=010", req_ready); end
            end
            if (c == 1) begin
                nChecks++;
                if ({cv_new_data, cv_x, cv_y, cv_z} !== {1'b1, 8'd5, 8'd7, 8'd40}) begin nErrors++; $display("[TB] FAIL single_issue got nd=%b x=%0d y=%0d z=%0d exp 1/5/7/40", cv_new_data, cv_x, cv_y, cv_z); end
            end
            if (c == 2) begin
                nChecks++;
                if ({cv_new_data, cv_x} !== {1'b0, 8'd5}) begin nErrors++; $display("[TB] FAIL single_hold got nd=%b x=%0d exp 0/5", cv_new_data, cv_x); end
            end
            nChecks++;
            if (rsp_valid !== 1'(c == 4)) begin nErrors++; $display("[TB] FAIL single_rsp_valid c=%0d got=%b", c, rsp_valid); end
            if (c == 4) begin
                nChecks++;
                if ({rsp_id, rsp_theta, rsp_radius, rsp_z} !== {2'd1, 6'd19, 6'd2, 6'd40}) begin nErrors++; $display("[TB] FAIL single_result got id=%0d th=%0d r=%0d z=%0d exp 1/19/2/40", rsp_id, rsp_theta, rsp_radius, rsp_z); end
            end
            @(negedge clk_in);
        end
    endtask

    // Consumer stalled: exactly FIFO_DEPTH accepts, then drain in order
    task automatic test_backpressure();
        logic [2:0] expReady;
        for (int c = 0; c < 24; c++) begin
            req_valid = (c <= 15) ? 3'b111 : 3'b000;
            rsp_ready = (c >= 14);
            #1;
            if (c < 8)        expReady = 3'(1 << ((2 + c) % 3));
            else if (c == 15) expReady = 3'b010;
            else              expReady = 3'b000;
            nChecks++;
            if (req_ready !== expReady) begin nErrors++; $display("[TB] FAIL bp_req_ready c=%0d got=%b exp=%b", c, req_ready, expReady); end
            nChecks++;
            if (rsp_valid !== 1'(c >= 4 && c <= 22)) begin nErrors++; $display("[TB] FAIL bp_rsp_valid c=%0d got=%b", c, rsp_valid); end
            if (c >= 4 && c <= 22) begin
                nChecks++;
                if (rsp_id !== ((c < 14) ? 2'd2 : 2'((c - 12) % 3))) begin nErrors++; $display("[TB] FAIL bp_rsp_id c=%0d got=%0d", c, rsp_id); end
            end
            if (c == 23) begin
                nChecks++;
                if (sync_err !== 1'b0) begin nErrors++; $display("[TB] FAIL bp_sync_err got=%b exp=0", sync_err); end
            end
            @(negedge clk_in);
        end
    endtask

    // enable_in drops right after two accepts; both results still drain
    task automatic test_enable_drain();
        logic [2:0] expReady;
        rsp_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            req_valid = (c <= 3) ? 3'b111 : 3'b000;
            enable_in = (c < 2);
            #1;
            expReady = (c == 0) ? 3'b100 : (c == 1) ? 3'b001 : 3'b000;
            nChecks++;
            if (req_ready !== expReady) begin nErrors++; $display("[TB] FAIL en_req_ready c=%0d got=%b exp=%b", c, req_ready, expReady); end
            nChecks++;
            if (cv_new_data !== 1'(c == 1 || c == 2)) begin nErrors++; $display("[TB] FAIL en_cv_new_data c=%0d got=%b", c, cv_new_data); end
            nChecks++;
            if (rsp_valid !== 1'(c == 4 || c == 5)) begin nErrors++; $display("[TB] FAIL en_rsp_valid c=%0d got=%b", c, rsp_valid); end
            if (c == 4 || c == 5) begin
                nChecks++;
                if (rsp_id !== ((c == 4) ? 2'd2 : 2'd0)) begin nErrors++; $display("[TB] FAIL en_rsp_id c=%0d got=%0d", c, rsp_id); end
            end
            @(negedge clk_in);
        end
        enable_in = 1'b1;
    endtask

    // Spurious converter strobe with an empty tag pipe
    task automatic test_sync_err();
        for (int c = 0; c < 4; c++) begin
            inject = (c == 0);
            #1;
            nChecks++;
            if (sync_err !== 1'(c >= 1)) begin nErrors++; $display("[TB] FAIL sync_err c=%0d got=%b exp=%b", c, sync_err, c >= 1); end
            nChecks++;
            if (rsp_valid !== 1'b0) begin nErrors++; $display("[TB] FAIL sync_rsp_valid c=%0d got=%b exp=0", c, rsp_valid); end
            @(negedge clk_in);
        end
        inject = 1'b0;
    endtask

    // Reset with 3 points in flight and 2 in the FIFO
    task automatic test_reset_midflight();
        logic [2:0] expReady;
        for (int c = 0; c < 12; c++) begin
            req_valid = (c <= 4 || c == 6) ? 3'b111 : 3'b000;
            rst_in    = (c == 5);
            rsp_ready = (c >= 6);
            #1;
            if (c <= 4) begin
                expReady = 3'(1 << ((1 + c) % 3));
                nChecks++;
                if (req_ready !== expReady) begin nErrors++; $display("[TB] FAIL mid_req_ready c=%0d got=%b exp=%b", c, req_ready, expReady); end
            end
            if (c == 5) begin
                nChecks++;
                if ({rsp_valid, rsp_id, sync_err} !== {1'b1, 2'd1, 1'b1}) begin nErrors++; $display("[TB] FAIL mid_pre_reset got v=%b id=%0d se=%b exp 1/1/1", rsp_valid, rsp_id, sync_err); end
            end
            if (c == 6) begin
                nChecks++;
                if ({cv_new_data, sync_err} !== 2'b00) begin nErrors++; $display("[TB] FAIL mid_post_reset got nd=%b se=%b exp 0/0", cv_new_data, sync_err); end
                nChecks++;
                if (req_ready !== 3'b001) begin nErrors++; $display("[TB] FAIL mid_first_grant got=%b exp=001", req_ready); end
            end
            if (c >= 6) begin
                nChecks++;
                if (rsp_valid !== 1'(c == 10)) begin nErrors++; $display("[TB] FAIL mid_rsp_valid c=%0d got=%b", c, rsp_valid); end
            end
            if (c == 10) begin
                nChecks++;
                if (rsp_id !== 2'd0) begin nErrors++; $display("[TB] FAIL mid_rsp_id got=%0d exp=0", rsp_id); end
            end
            @(negedge clk_in);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_point();
        test_backpressure();
        test_enable_drain();
        test_sync_err();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

    // Safety net so the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
